cpu_apb_bridge: RTL and testbench

//  Upstream APB master for the peripheral bus: turns one CPU load/store request (valid/ready) into an APB3 transfer.

---
 rtl/apb_pkg.sv | 36 +++
 rtl/apb_timeout_timer.sv | 42 ++++
 rtl/cpu_apb_bridge.sv | 161 ++++++++++++++++
 tb/tb_cpu_apb_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states, peripheral address map,
// default window/timeout constants and the window decode helper.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Peripheral register map, shared with apb_peripheral.
    localparam logic [31:0] APB_ADDR_LED = 32'h2000_0000;
    localparam logic [31:0] APB_ADDR_SW1 = 32'h2000_0004;
    localparam logic [31:0] APB_ADDR_SW2 = 32'h2000_0008;
    localparam logic [31:0] APB_ADDR_SEG = 32'h2000_000C;

    localparam logic [31:0] APB_BASE_ADDR      = APB_ADDR_LED;
    localparam logic [31:0] APB_WINDOW_SIZE    = 32'h0000_0010;
    localparam int          APB_TIMEOUT_CYCLES = 16;

    // Word-aligned and inside [base, base+size); the 33-bit compare keeps a
    // window that ends at the top of the address space from wrapping.
    function automatic logic addr_decode_ok(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/apb_timeout_timer.sv
// Counts ACCESS cycles spent waiting for Pready; expired_o flags the last
// allowed wait cycle so the bridge can abort on that same cycle.
module apb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/cpu_apb_bridge.sv
// CPU load/store (valid/ready) to APB3 master bridge. One transfer in
// flight: decode, SETUP, ACCESS with wait/timeout handling, then a held
// response until the CPU accepts it.
module cpu_apb_bridge
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = APB_BASE_ADDR,
    parameter logic [31:0] WINDOW_SIZE    = APB_WINDOW_SIZE,
    parameter int          TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic        Pclk,
    input  logic        Prst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Paddr,
    output logic        Pwrite,
    output logic        Psel,
    output logic        Penable,
    output logic [31:0] Pwdata,
    input  logic [31:0] Prdata,
    input  logic        Pready,
    input  logic        Pslverr
);

    apb_state_e  state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic decode_ok;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign decode_ok    = addr_decode_ok(req_addr, BASE_ADDR, WINDOW_SIZE);
    assign timer_clear  = (state_q == ST_SETUP);
    assign timer_enable = (state_q == ST_ACCESS) && !Pready;

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timer
            apb_timeout_timer #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_timer (
                .clk      (Pclk),
                .rst_n    (Prst),
                .clear_i  (timer_clear),
                .enable_i (timer_enable),
                .expired_o(timer_expired)
            );
        end else begin : g_no_timer
            assign timer_expired = 1'b0;
        end
    endgenerate

    // State register; an asynchronous reset abandons any transfer in flight.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Pready wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = decode_ok ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (Pready || timer_expired) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output next-values: bus strobes follow the next state so every output
    // leaves a flop; request fields and response payload update on events.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = !decode_ok;
                    if (decode_ok) begin
                        paddr_d  = req_addr;
                        pwrite_d = req_write;
                        pwdata_d = req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (Pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : Prdata;
                    rsp_err_d   = Pslverr;
                end else if (timer_expired) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    // NOTE: every register here is a plain flop with a reset value; there is
    // no memory array, so nothing is left uninitialised after reset.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign Paddr     = paddr_q;
    assign Pwrite    = pwrite_q;
    assign Pwdata    = pwdata_q;
    assign Psel      = psel_q;
    assign Penable   = penable_q;

endmodule

// File: tb/tb_cpu_apb_bridge.sv
// Bench for cpu_apb_bridge: a driver task plays CPU and APB slave, expected
// responses are queued at request time and compared when rsp_valid rises.
module tb_cpu_apb_bridge;

    logic        Pclk = 1'b0;
    logic        Prst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] Paddr;
    logic        Pwrite;
    logic        Psel;
    logic        Penable;
    logic [31:0] Pwdata;
    logic [31:0] Prdata = '0;
    logic        Pready = 1'b0;
    logic        Pslverr = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          latency;
        int          accesses;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 Pclk = ~Pclk;

    cpu_apb_bridge dut (
        .Pclk     (Pclk),
        .Prst     (Prst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .Paddr    (Paddr),
        .Pwrite   (Pwrite),
        .Psel     (Psel),
        .Penable  (Penable),
        .Pwdata   (Pwdata),
        .Prdata   (Prdata),
        .Pready   (Pready),
        .Pslverr  (Pslverr)
    );

    // One CPU transfer. waits<0 means the slave never raises Pready.
    // hold is the number of cycles rsp_ready stays low once rsp_valid is up.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int waits, input logic slverr, input logic [31:0] rdata,
                           input int hold, input string name);
        exp_t e;
        exp_t got;
        int   access_n;
        int   psel_n;
        int   cyc;
        logic in_win;

        in_win = (addr >= 32'h2000_0000) && (addr < 32'h2000_0010) && (addr[1:0] == 2'b00);
        if (!in_win) begin
            e.rdata = '0; e.err = 1'b1; e.latency = 1; e.accesses = 0;
        end else if (waits < 0 || waits >= 16) begin
            e.rdata = '0; e.err = 1'b1; e.latency = 18; e.accesses = 16;
        end else begin
            e.rdata = wr ? 32'h0 : rdata; e.err = slverr;
            e.latency = 3 + waits; e.accesses = waits + 1;
        end
        exp_q.push_back(e);

        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s req_ready at request: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata;
        @(posedge Pclk); @(negedge Pclk);
        req_valid = 1'b0;

        access_n = 0; psel_n = 0; cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 60) begin
            if (Psel === 1'b1) psel_n++;
            if (cyc == 1 && in_win) begin
                tests_run++;
                if (Psel !== 1'b1 || Penable !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s setup Psel/Penable: got %b/%b want 1/0", name, Psel, Penable);
                end
            end
            if (Psel === 1'b1 && Penable === 1'b1) begin
                access_n++;
                tests_run++;
                if (Paddr !== addr || Pwrite !== wr || (wr && Pwdata !== wdata)) begin
                    tests_failed++;
                    $display("FAIL %s access bus: got addr %h wr %b wdata %h want addr %h wr %b wdata %h",
                             name, Paddr, Pwrite, Pwdata, addr, wr, wdata);
                end
                Pready  = (waits >= 0) && (access_n > waits);
                Prdata  = rdata;
                Pslverr = slverr;
            end else begin
                Pready = 1'b0;
            end
            @(posedge Pclk); @(negedge Pclk);
            cyc++;
        end
        Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;

        got = exp_q.pop_front();
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s no response within 60 cycles: got rsp_valid %b want 1", name, rsp_valid);
            Prst = 1'b0; @(negedge Pclk); Prst = 1'b1; @(negedge Pclk);
            return;
        end
        tests_run++;
        if (rsp_rdata !== got.rdata || rsp_err !== got.err) begin
            tests_failed++;
            $display("FAIL %s response: got rdata %h err %b want rdata %h err %b",
                     name, rsp_rdata, rsp_err, got.rdata, got.err);
        end
        tests_run++;
        if (cyc != got.latency || access_n != got.accesses) begin
            tests_failed++;
            $display("FAIL %s timing: got latency %0d accesses %0d want latency %0d accesses %0d",
                     name, cyc, access_n, got.latency, got.accesses);
        end
        tests_run++;
        if (psel_n != (got.accesses > 0 ? got.accesses + 1 : 0) || Psel !== 1'b0 || Penable !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s psel cycles: got %0d (Psel now %b) want %0d (Psel now 0)",
                     name, psel_n, Psel, (got.accesses > 0 ? got.accesses + 1 : 0));
        end

        for (int h = 0; h < hold; h++) begin
            @(posedge Pclk); @(negedge Pclk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== got.rdata || rsp_err !== got.err ||
                req_ready !== 1'b0 || Psel !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s hold %0d: got valid %b rdata %h err %b req_ready %b Psel %b want 1 %h %b 0 0",
                         name, h, rsp_valid, rsp_rdata, rsp_err, req_ready, Psel, got.rdata, got.err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge Pclk); @(negedge Pclk);
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s after handshake: got rsp_valid %b req_ready %b want 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
            Psel !== 1'b0 || Penable !== 1'b0 || Paddr !== 32'h0 || Pwrite !== 1'b0 || Pwdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset outputs: got req_ready %b rsp_valid %b rdata %h err %b Psel %b Penable %b Paddr %h Pwrite %b Pwdata %h",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, Psel, Penable, Paddr, Pwrite, Pwdata);
        end
        @(negedge Pclk); Prst = 1'b1;
        @(negedge Pclk);
        tests_run++;
        if (req_ready !== 1'b1 || Psel !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset release: got req_ready %b Psel %b rsp_valid %b want 1 0 0", req_ready, Psel, rsp_valid);
        end
    endtask

    task automatic test_store();
        do_xfer(32'h2000_0000, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, 32'hFFFF_FFFF, 0, "t1_store");
    endtask

    task automatic test_wait_load();
        do_xfer(32'h2000_0004, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 0, "t2_wait_load");
    endtask

    task automatic test_decode_err();
        do_xfer(32'h3000_0000, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_0001, 0, "t3_out_of_window");
        do_xfer(32'h2000_0002, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_0002, 0, "t3_misaligned");
        do_xfer(32'h2000_0010, 1'b1, 32'h5555_0000, 0, 1'b0, 32'h0, 0, "t3_one_past_end");
        do_xfer(32'h1FFF_FFFC, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_0003, 0, "t3_below_base");
        do_xfer(32'h2000_000C, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 0, "t3_last_word");
    endtask

    task automatic test_timeout_slverr();
        do_xfer(32'h2000_0008, 1'b0, 32'h0, -1, 1'b0, 32'h7777_7777, 0, "t4_timeout");
        do_xfer(32'h2000_0008, 1'b0, 32'h0, 15, 1'b0, 32'h1357_9BDF, 0, "t4_ready_on_last_cycle");
        do_xfer(32'h2000_0004, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0, "t4_slverr_read");
        do_xfer(32'h2000_000C, 1'b1, 32'hCAFE_0000, 0, 1'b1, 32'h0, 0, "t4_slverr_write");
    endtask

    task automatic test_backpressure();
        do_xfer(32'h2000_0008, 1'b0, 32'h0, 0, 1'b0, 32'h0F0F_1234, 5, "t5_backpressure");
        do_xfer(32'h2000_0000, 1'b1, 32'h0000_00FF, 0, 1'b0, 32'h0, 0, "t5_next_request");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_xfer(32'h2000_0000 + 32'($urandom_range(0, 3) * 4), 1'(i % 2), $urandom,
                    $urandom_range(0, 2), 1'b0, $urandom, 0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        int n;
        req_valid = 1'b1; req_addr = 32'h2000_0008; req_write = 1'b0; req_wdata = '0;
        @(posedge Pclk); @(negedge Pclk);
        req_valid = 1'b0; Pready = 1'b0;
        n = 0;
        while (!(Psel === 1'b1 && Penable === 1'b1) && n < 10) begin
            @(posedge Pclk); @(negedge Pclk); n++;
        end
        tests_run++;
        if (Penable !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6 reach access: got Penable %b want 1", Penable);
        end
        @(posedge Pclk); @(negedge Pclk);
        Prst = 1'b0;
        #1;
        tests_run++;
        if (Psel !== 1'b0 || Penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6 async reset: got Psel %b Penable %b rsp_valid %b req_ready %b want 0 0 0 1",
                     Psel, Penable, rsp_valid, req_ready);
        end
        @(negedge Pclk); Prst = 1'b1;
        @(negedge Pclk);
        do_xfer(32'h2000_000C, 1'b1, 32'h3C3C_3C3C, 0, 1'b0, 32'h0, 0, "t6_after_reset");
    endtask

    initial begin
        test_reset();
        test_store();
        test_wait_load();
        test_decode_err();
        test_timeout_slverr();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
